tcm_mem_ctrl: RTL and testbench

- Front-end controller for the 64KB dual-port tightly-coupled memory: 16K x 32-bit words, byte-enable writes, 1-cycle registered read, read-first.
- Port 0 is dedicated to core instruction fetch (read-only).
- Port 1 is shared between the core data port and an external loader/debug bus, with round-robin arbitration, an external burst lock, address range checking and response routing.

---
 rtl/tcm_mem_pkg.sv | 31 +++
 rtl/tcm_rr_arb2.sv | 58 +++++
 rtl/tcm_mem_ctrl.sv | 120 ++++++++++++
 tb/tb_tcm_mem_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_mem_pkg.sv
// Shared encodings and the address-window helper for the TCM front-end.
// Holds no state; provides the owner tags, arbiter states and the request bundle.
package tcm_mem_pkg;

    localparam int WORD_LSB = 2;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_DMEM = 2'd1,
        OWNER_EXT  = 2'd2
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wr;
    } req_t;

    // True when addr lies in the 2^(addr_w+2)-byte window that starts at base.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int          addr_w);
        return ((addr ^ base) >> (addr_w + WORD_LSB)) == 32'd0;
    endfunction

endpackage

// File: rtl/tcm_rr_arb2.sv
// Two-way round-robin arbiter with a burst lock held by requester 1; grant is combinational.
// Zero latency; a losing requester simply sees no grant, and nothing is granted while in reset.
module tcm_rr_arb2
    import tcm_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       lock_hold,
    output logic [1:0] gnt
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       favour_q;

    always_comb begin
        gnt     = 2'b00;
        state_d = state_q;
        if (rst_n) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (&req) begin
                        gnt = favour_q ? 2'b10 : 2'b01;
                    end else begin
                        gnt = req;
                    end
                    if (gnt[1] && lock_hold) begin
                        state_d = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // Requester 0 is starved until requester 1 closes its burst.
                    gnt[1] = req[1];
                    if (req[1] && !lock_hold) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            favour_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt[0]) begin
                favour_q <= 1'b1;
            end else if (gnt[1]) begin
                favour_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tcm_mem_ctrl.sv
// TCM front-end: fetch on RAM port 0, arbitrated dmem/ext on port 1, range check and response routing.
// Responses arrive 1 cycle after accept with no backpressure; requests stall only by being left unaccepted.
module tcm_mem_ctrl
    import tcm_mem_pkg::*;
#(
    parameter logic [31:0] TCM_BASE = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ifetch_rd_i,
    input  logic [31:0]       ifetch_pc_i,
    output logic              ifetch_accept_o,
    output logic              ifetch_valid_o,
    output logic [31:0]       ifetch_instr_o,
    output logic              ifetch_error_o,
    input  logic [31:0]       dmem_addr_i,
    input  logic [31:0]       dmem_data_wr_i,
    input  logic              dmem_rd_i,
    input  logic [3:0]        dmem_wr_i,
    output logic              dmem_accept_o,
    output logic              dmem_ack_o,
    output logic [31:0]       dmem_data_rd_o,
    output logic              dmem_error_o,
    input  logic [31:0]       ext_addr_i,
    input  logic [31:0]       ext_data_wr_i,
    input  logic              ext_rd_i,
    input  logic [3:0]        ext_wr_i,
    input  logic              ext_last_i,
    output logic              ext_accept_o,
    output logic              ext_ack_o,
    output logic [31:0]       ext_data_rd_o,
    output logic              ext_error_o,
    output logic [ADDR_W-1:0] ram_addr0_o,
    output logic [3:0]        ram_wr0_o,
    input  logic [31:0]       ram_data0_i,
    output logic [ADDR_W-1:0] ram_addr1_o,
    output logic [31:0]       ram_data1_o,
    output logic [3:0]        ram_wr1_o,
    input  logic [31:0]       ram_data1_i
);

    logic              req_dmem;
    logic              req_ext;
    logic [1:0]        gnt;
    logic              granted;
    logic              in_rng1;
    req_t              sel;
    logic [ADDR_W-1:0] addr1_q;
    logic              fetch_vld_q;
    logic              fetch_err_q;
    owner_e            owner_q;
    logic              rsp_err_q;
    logic              rsp_wr_q;
    logic [31:0]       rsp_data;

    assign req_dmem = dmem_rd_i | (|dmem_wr_i);
    assign req_ext  = ext_rd_i | (|ext_wr_i);

    tcm_rr_arb2 u_arb (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .req       ({req_ext, req_dmem}),
        .lock_hold (~ext_last_i),
        .gnt       (gnt)
    );

    assign dmem_accept_o = gnt[0];
    assign ext_accept_o  = gnt[1];
    assign granted       = |gnt;

    always_comb begin
        sel = gnt[1] ? '{addr: ext_addr_i,  data: ext_data_wr_i,  wr: ext_wr_i}
                     : '{addr: dmem_addr_i, data: dmem_data_wr_i, wr: dmem_wr_i};
    end

    assign in_rng1     = in_window(sel.addr, TCM_BASE, ADDR_W);
    assign ram_addr1_o = granted ? sel.addr[ADDR_W+1:2] : addr1_q;
    assign ram_data1_o = granted ? sel.data : 32'd0;
    assign ram_wr1_o   = (granted && in_rng1) ? sel.wr : 4'b0000;

    assign ifetch_accept_o = rst_i;
    assign ram_addr0_o     = rst_i ? ifetch_pc_i[ADDR_W+1:2] : '0;
    assign ram_wr0_o       = 4'b0000;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr1_q     <= '0;
            fetch_vld_q <= 1'b0;
            fetch_err_q <= 1'b0;
            owner_q     <= OWNER_NONE;
            rsp_err_q   <= 1'b0;
            rsp_wr_q    <= 1'b0;
        end else begin
            fetch_vld_q <= ifetch_rd_i;
            fetch_err_q <= ifetch_rd_i && !in_window(ifetch_pc_i, TCM_BASE, ADDR_W);
            if (granted) begin
                addr1_q <= sel.addr[ADDR_W+1:2];
            end
            owner_q   <= gnt[0] ? OWNER_DMEM : (gnt[1] ? OWNER_EXT : OWNER_NONE);
            rsp_err_q <= granted && !in_rng1;
            rsp_wr_q  <= granted && (|sel.wr);
        end
    end

    assign ifetch_valid_o = fetch_vld_q;
    assign ifetch_error_o = fetch_vld_q && fetch_err_q;
    assign ifetch_instr_o = (fetch_vld_q && !fetch_err_q) ? ram_data0_i : 32'd0;

    // Writes and range errors return zero data rather than whatever the RAM drove.
    assign rsp_data       = (rsp_err_q || rsp_wr_q) ? 32'd0 : ram_data1_i;

    assign dmem_ack_o     = (owner_q == OWNER_DMEM);
    assign dmem_error_o   = dmem_ack_o && rsp_err_q;
    assign dmem_data_rd_o = dmem_ack_o ? rsp_data : 32'd0;
    assign ext_ack_o      = (owner_q == OWNER_EXT);
    assign ext_error_o    = ext_ack_o && rsp_err_q;
    assign ext_data_rd_o  = ext_ack_o ? rsp_data : 32'd0;

endmodule

// File: tb/tb_tcm_mem_ctrl.sv
// Bench for tcm_mem_ctrl with a behavioural read-first dual-port RAM and per-requester response scoreboards.
module tb_tcm_mem_ctrl;

    localparam logic [31:0] B = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ifetch_rd_i;
    logic [31:0] ifetch_pc_i;
    logic        ifetch_accept_o, ifetch_valid_o, ifetch_error_o;
    logic [31:0] ifetch_instr_o;
    logic [31:0] dmem_addr_i, dmem_data_wr_i;
    logic        dmem_rd_i;
    logic [3:0]  dmem_wr_i;
    logic        dmem_accept_o, dmem_ack_o, dmem_error_o;
    logic [31:0] dmem_data_rd_o;
    logic [31:0] ext_addr_i, ext_data_wr_i;
    logic        ext_rd_i, ext_last_i;
    logic [3:0]  ext_wr_i;
    logic        ext_accept_o, ext_ack_o, ext_error_o;
    logic [31:0] ext_data_rd_o;
    logic [13:0] ram_addr0_o, ram_addr1_o;
    logic [3:0]  ram_wr0_o, ram_wr1_o;
    logic [31:0] ram_data0_i, ram_data1_i, ram_data1_o;

    logic [31:0] mem [0:16383];
    logic        load_en;

    int   errors = 0;
    int   checks = 0;
    rsp_t fq[$];
    rsp_t dq[$];
    rsp_t eq[$];

    always #5 clk_i = ~clk_i;

    tcm_mem_ctrl #(.TCM_BASE(B), .ADDR_W(14)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifetch_rd_i(ifetch_rd_i), .ifetch_pc_i(ifetch_pc_i),
        .ifetch_accept_o(ifetch_accept_o), .ifetch_valid_o(ifetch_valid_o),
        .ifetch_instr_o(ifetch_instr_o), .ifetch_error_o(ifetch_error_o),
        .dmem_addr_i(dmem_addr_i), .dmem_data_wr_i(dmem_data_wr_i),
        .dmem_rd_i(dmem_rd_i), .dmem_wr_i(dmem_wr_i),
        .dmem_accept_o(dmem_accept_o), .dmem_ack_o(dmem_ack_o),
        .dmem_data_rd_o(dmem_data_rd_o), .dmem_error_o(dmem_error_o),
        .ext_addr_i(ext_addr_i), .ext_data_wr_i(ext_data_wr_i),
        .ext_rd_i(ext_rd_i), .ext_wr_i(ext_wr_i), .ext_last_i(ext_last_i),
        .ext_accept_o(ext_accept_o), .ext_ack_o(ext_ack_o),
        .ext_data_rd_o(ext_data_rd_o), .ext_error_o(ext_error_o),
        .ram_addr0_o(ram_addr0_o), .ram_wr0_o(ram_wr0_o), .ram_data0_i(ram_data0_i),
        .ram_addr1_o(ram_addr1_o), .ram_data1_o(ram_data1_o),
        .ram_wr1_o(ram_wr1_o), .ram_data1_i(ram_data1_i)
    );

    // Read-first RAM; the first clock fills it with C0DE_xxxx (xxxx = word index) plus two preset words.
    always @(posedge clk_i) begin
        if (load_en) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 32'hC0DE_0000 | i;
            mem[14'h100] <= 32'hDEAD_BEEF;
            mem[14'h005] <= 32'hAAAA_AAAA;
        end else begin
            ram_data0_i <= mem[ram_addr0_o];
            ram_data1_i <= mem[ram_addr1_o];
            for (int b = 0; b < 4; b++)
                if (ram_wr1_o[b]) mem[ram_addr1_o][8*b +: 8] <= ram_data1_o[8*b +: 8];
        end
    end

    // Response monitor: every ack/valid must match the oldest expectation for that requester.
    always @(negedge clk_i) begin
        rsp_t e;
        if (ifetch_valid_o) begin
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL fetch_rsp: unexpected valid instr=%h err=%b", ifetch_instr_o, ifetch_error_o);
            end else begin
                e = fq.pop_front();
                if ({ifetch_instr_o, ifetch_error_o} !== e) begin
                    errors++;
                    $display("FAIL fetch_rsp: got %h/%b expected %h/%b", ifetch_instr_o, ifetch_error_o, e.data, e.err);
                end
            end
        end
        if (dmem_ack_o) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL dmem_rsp: unexpected ack data=%h err=%b", dmem_data_rd_o, dmem_error_o);
            end else begin
                e = dq.pop_front();
                if ({dmem_data_rd_o, dmem_error_o} !== e) begin
                    errors++;
                    $display("FAIL dmem_rsp: got %h/%b expected %h/%b", dmem_data_rd_o, dmem_error_o, e.data, e.err);
                end
            end
        end
        if (ext_ack_o) begin
            checks++;
            if (eq.size() == 0) begin
                errors++;
                $display("FAIL ext_rsp: unexpected ack data=%h err=%b", ext_data_rd_o, ext_error_o);
            end else begin
                e = eq.pop_front();
                if ({ext_data_rd_o, ext_error_o} !== e) begin
                    errors++;
                    $display("FAIL ext_rsp: got %h/%b expected %h/%b", ext_data_rd_o, ext_error_o, e.data, e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        ifetch_rd_i = 1'b0; dmem_rd_i = 1'b0; dmem_wr_i = 4'h0;
        ext_rd_i = 1'b0; ext_wr_i = 4'h0; ext_last_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0; load_en = 1'b1;
        idle();
        ifetch_pc_i = '0; dmem_addr_i = '0; dmem_data_wr_i = '0; ext_addr_i = '0; ext_data_wr_i = '0;
        step();
        load_en = 1'b0;

        // Requests during reset must be refused and produce nothing.
        ifetch_rd_i = 1'b1; ifetch_pc_i = B + 32'h400;
        dmem_wr_i = 4'hF; dmem_addr_i = B + 32'h14; dmem_data_wr_i = 32'hFFFF_FFFF;
        ext_rd_i = 1'b1; ext_addr_i = B + 32'h80;
        @(negedge clk_i);
        chk("rst_ifetch_acc", {31'd0, ifetch_accept_o}, 32'd0);
        chk("rst_dmem_acc", {31'd0, dmem_accept_o}, 32'd0);
        chk("rst_ext_acc", {31'd0, ext_accept_o}, 32'd0);
        chk("rst_ram_wr1", {28'd0, ram_wr1_o}, 32'd0);
        chk("rst_ram_addr0", {18'd0, ram_addr0_o}, 32'd0);
        chk("rst_ram_addr1", {18'd0, ram_addr1_o}, 32'd0);
        chk("rst_acks", {29'd0, ifetch_valid_o, dmem_ack_o, ext_ack_o}, 32'd0);
        chk("rst_data", dmem_data_rd_o | ext_data_rd_o | ifetch_instr_o, 32'd0);
        idle();
        step();
        rst_i = 1'b1;

        // Fetch: in-range word 0x100, then an out-of-range fetch.
        step(); ifetch_rd_i = 1'b1; ifetch_pc_i = B + 32'h400;
        @(negedge clk_i); chk("fetch_acc", {31'd0, ifetch_accept_o}, 32'd1);
        fq.push_back('{32'hDEAD_BEEF, 1'b0});
        step(); ifetch_pc_i = 32'h0000_0400;
        @(negedge clk_i); chk("fetch_err_acc", {31'd0, ifetch_accept_o}, 32'd1);
        fq.push_back('{32'h0, 1'b1});
        step(); idle();

        // Contention: both read continuously, grants alternate starting with dmem.
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin
                dmem_rd_i = 1'b1; dmem_addr_i = B + 32'h40;
                ext_rd_i = 1'b1; ext_addr_i = B + 32'h80;
            end
            @(negedge clk_i);
            chk($sformatf("rr_dmem_acc%0d", k), {31'd0, dmem_accept_o}, {31'd0, (k % 2) == 0});
            chk($sformatf("rr_ext_acc%0d", k), {31'd0, ext_accept_o}, {31'd0, (k % 2) == 1});
            if ((k % 2) == 0) dq.push_back('{32'hC0DE_0010, 1'b0});
            else eq.push_back('{32'hC0DE_0020, 1'b0});
        end
        step(); idle();

        // Byte-enable write to word 5, read back on the very next cycle.
        step(); dmem_wr_i = 4'b0101; dmem_addr_i = B + 32'h14; dmem_data_wr_i = 32'h1122_3344;
        @(negedge clk_i); chk("bw_acc", {31'd0, dmem_accept_o}, 32'd1);
        dq.push_back('{32'h0, 1'b0});
        step(); dmem_wr_i = 4'h0; dmem_rd_i = 1'b1;
        @(negedge clk_i); chk("bw_rd_acc", {31'd0, dmem_accept_o}, 32'd1);
        dq.push_back('{32'hAA22_AA44, 1'b0});
        step(); idle();

        // Burst lock: 3 ext writes lock out dmem; dmem then reads a word the burst wrote.
        for (int k = 0; k < 4; k++) begin
            step();
            dmem_rd_i = 1'b1; dmem_addr_i = B + 32'hC4;
            if (k < 3) begin
                ext_wr_i = 4'hF; ext_addr_i = B + 32'hC0 + 32'(4 * k);
                ext_data_wr_i = 32'hE000_0030 + 32'(k); ext_last_i = (k == 2);
            end else begin
                ext_wr_i = 4'h0; ext_last_i = 1'b1;
            end
            @(negedge clk_i);
            chk($sformatf("lock_dmem_acc%0d", k), {31'd0, dmem_accept_o}, {31'd0, k == 3});
            chk($sformatf("lock_ext_acc%0d", k), {31'd0, ext_accept_o}, {31'd0, k < 3});
            if (k < 3) eq.push_back('{32'h0, 1'b0});
            else dq.push_back('{32'hE000_0031, 1'b0});
        end
        step(); idle();

        // Reset while locked with an ext read in flight.
        step(); ext_wr_i = 4'hF; ext_addr_i = B + 32'h100; ext_data_wr_i = 32'h5555_0040; ext_last_i = 1'b0;
        @(negedge clk_i); chk("mr_ext_acc", {31'd0, ext_accept_o}, 32'd1);
        eq.push_back('{32'h0, 1'b0});
        step(); ext_wr_i = 4'h0; dmem_rd_i = 1'b1; dmem_addr_i = B + 32'h104;
        @(negedge clk_i); chk("mr_lock_idle_dmem_acc", {31'd0, dmem_accept_o}, 32'd0);
        step(); ext_rd_i = 1'b1; ext_addr_i = B + 32'h100;
        @(negedge clk_i);
        chk("mr_ext_rd_acc", {31'd0, ext_accept_o}, 32'd1);
        chk("mr_dmem_blocked", {31'd0, dmem_accept_o}, 32'd0);
        rst_i = 1'b0;
        #1 chk("mr_in_rst_acc", {30'd0, dmem_accept_o, ext_accept_o}, 32'd0);
        step(); idle();
        @(negedge clk_i); chk("mr_no_ack", {30'd0, dmem_ack_o, ext_ack_o}, 32'd0);
        step(); rst_i = 1'b1;
        step(); dmem_rd_i = 1'b1; dmem_addr_i = B + 32'h100;
        @(negedge clk_i); chk("mr_dmem_acc_after", {31'd0, dmem_accept_o}, 32'd1);
        dq.push_back('{32'h5555_0040, 1'b0});
        step(); idle();

        // Out-of-range accesses: write suppressed, error response, memory untouched.
        step(); ext_wr_i = 4'hF; ext_addr_i = 32'h0000_0010; ext_data_wr_i = 32'hBAD0_BAD0;
        @(negedge clk_i);
        chk("oor_ext_acc", {31'd0, ext_accept_o}, 32'd1);
        chk("oor_ram_wr1", {28'd0, ram_wr1_o}, 32'd0);
        eq.push_back('{32'h0, 1'b1});
        step(); ext_wr_i = 4'h0; ext_rd_i = 1'b1; ext_addr_i = B + 32'h10;
        @(negedge clk_i); chk("oor_rb_acc", {31'd0, ext_accept_o}, 32'd1);
        eq.push_back('{32'hC0DE_0004, 1'b0});
        step(); ext_rd_i = 1'b0; dmem_rd_i = 1'b1; dmem_addr_i = 32'h0000_0040;
        @(negedge clk_i); chk("oor_dmem_acc", {31'd0, dmem_accept_o}, 32'd1);
        dq.push_back('{32'h0, 1'b1});
        step(); idle();

        repeat (3) @(negedge clk_i);
        chk("fetch_q_drained", fq.size(), 32'd0);
        chk("dmem_q_drained", dq.size(), 32'd0);
        chk("ext_q_drained", eq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
